ahb2apb_bridge_mp: RTL and testbench

//  Single-clock AHB-Lite slave to multi-slave APB master bridge; parametrised successor of the dual-clock bridge.

---
 rtl/ahb_apb_pkg.sv | 41 ++++
 rtl/ahb2apb_slv_decode.sv | 32 +++
 rtl/ahb2apb_bridge_mp.sv | 203 ++++++++++++++++++++
 tb/tb_ahb2apb_bridge_mp.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: HTRANS/HRESP codes, FSM states
// and a constant-safe ceil(log2) helper.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // IDLE and BUSY carry no transfer; only NONSEQ/SEQ start one.
  function automatic logic trans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_IDLE:   act = 1'b0;
      HTRANS_BUSY:   act = 1'b0;
      HTRANS_NONSEQ: act = 1'b1;
      HTRANS_SEQ:    act = 1'b1;
      default:       act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb2apb_slv_decode.sv
// Combinational APB window decoder: address -> hit flag, one-hot select and slave index.
// Offset arithmetic wraps at ADDR_W bits, so addresses below the base fall out as misses.
module ahb2apb_slv_decode
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_SLV  = 4,
  parameter int                IDX_W    = 2,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h0020_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0004_0000
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel,
  output logic [IDX_W-1:0]   idx
);

  localparam int SHIFT = clog2(SLV_SIZE);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] slot;

  always_comb begin
    off  = addr - SLV_BASE;
    slot = off >> SHIFT;
    hit  = (slot < ADDR_W'(NUM_SLV));
    idx  = slot[IDX_W-1:0];
    sel  = '0;
    for (int i = 0; i < NUM_SLV; i++) sel[i] = hit && (slot == ADDR_W'(i));
  end

endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// Single-clock AHB-Lite slave to NUM_SLV-way APB master bridge with two-cycle ERROR and PREADY timeout.
// Define AHB2APB_APB4_EN to add the APB4 PSTRB/PPROT outputs.
// Handshake: an AHB transfer is taken when HSEL & HREADY & HTRANS active while HREADYOUT=1 (IDLE/ERR2);
// an APB access completes on the first ACCESS cycle with PREADY of the selected slave high.
module ahb2apb_bridge_mp
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NUM_SLV  = 4,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h0020_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0004_0000,
  parameter int                TIMEOUT  = 256
) (
  input  logic                      ahb_clk,
  input  logic                      ahb_reset,
  input  logic                      HSEL,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [3:0]                HPROT,
  input  logic [DATA_W-1:0]         HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DATA_W-1:0]         HRDATA,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
`ifdef AHB2APB_APB4_EN
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [2:0]                PPROT,
`endif
  output logic [2:0]                dbg_state
);

  localparam int IDX_W = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 write_q, write_d;
  logic [NUM_SLV-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic [DATA_W-1:0]    hrdata_q, hrdata_d;
  logic [TMR_W-1:0]     timer_q, timer_d;

  logic                 dec_hit;
  logic [NUM_SLV-1:0]   dec_sel;
  logic [IDX_W-1:0]     dec_idx;
  logic                 accept, slv_ready, slv_err, timed_out;
  logic [DATA_W-1:0]    slv_rdata;

  ahb2apb_slv_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W),
    .SLV_BASE(SLV_BASE),
    .SLV_SIZE(SLV_SIZE)
  ) u_decode (
    .addr(HADDR),
    .hit (dec_hit),
    .sel (dec_sel),
    .idx (dec_idx)
  );

  always_comb begin
    accept    = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) && HSEL && HREADY && trans_active(HTRANS);
    slv_ready = PREADY[idx_q];
    slv_err   = PSLVERR[idx_q];
    slv_rdata = PRDATA[idx_q*DATA_W +: DATA_W];
    timed_out = (TIMEOUT != 0) && (int'(timer_q) == TIMEOUT - 1);
  end

  always_ff @(posedge ahb_clk) begin
    if (ahb_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // A completing PREADY wins over a timeout expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_d = dec_hit ? ST_SETUP : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (slv_ready)      state_d = slv_err ? ST_ERR1 : ST_IDLE;
        else if (timed_out) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    PSEL      = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_q : '0;
    PENABLE   = (state_q == ST_ACCESS);
    PWDATA    = ((state_q == ST_SETUP) && write_q) ? HWDATA : pwdata_q;
  end

  assign HRDATA    = hrdata_q;
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign dbg_state = state_q;

  // Write data arrives in the AHB data phase, which is the SETUP cycle.
  always_comb begin
    addr_d   = addr_q;
    write_d  = write_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    timer_d  = '0;
    if (accept && dec_hit) begin
      addr_d  = HADDR;
      write_d = HWRITE;
      sel_d   = dec_sel;
      idx_d   = dec_idx;
    end
    if ((state_q == ST_SETUP) && write_q) pwdata_d = HWDATA;
    if (state_q == ST_ACCESS) begin
      if (!slv_ready && !timed_out)       timer_d  = timer_q + 1'b1;
      else if (slv_ready && !slv_err && !write_q) hrdata_d = slv_rdata;
    end
  end

  always_ff @(posedge ahb_clk) begin
    if (ahb_reset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      timer_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      write_q  <= write_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      timer_q  <= timer_d;
    end
  end

`ifdef AHB2APB_APB4_EN
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = clog2(STRB_W);

  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              unused_hprot;

  // Byte b is written when it shares the 2^size-aligned block containing the start lane.
  function automatic logic [STRB_W-1:0] size_strb(input logic [2:0] size, input logic [LANE_W-1:0] lane);
    logic [STRB_W-1:0] m;
    m = '0;
    for (int b = 0; b < STRB_W; b++) m[b] = ((b >> size) == (int'(lane) >> size));
    return m;
  endfunction

  always_comb begin
    pstrb_d = pstrb_q;
    pprot_d = pprot_q;
    if (accept && dec_hit) begin
      pstrb_d = HWRITE ? size_strb(HSIZE, HADDR[LANE_W-1:0]) : '0;
      pprot_d = {~HPROT[0], 1'b1, HPROT[1]};
    end
  end

  always_ff @(posedge ahb_clk) begin
    if (ahb_reset) begin
      pstrb_q <= '0;
      pprot_q <= '0;
    end else begin
      pstrb_q <= pstrb_d;
      pprot_q <= pprot_d;
    end
  end

  assign PSTRB        = pstrb_q;
  assign PPROT        = pprot_q;
  assign unused_hprot = ^HPROT[3:2];
`else
  logic unused_sideband;
  assign unused_sideband = ^{HSIZE, HPROT};
`endif

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Directed bench for ahb2apb_bridge_mp: transaction-level expected-cycle model plus literal pins.
// Define AHB2APB_APB4_EN to also exercise PSTRB/PPROT.
module tb_ahb2apb_bridge_mp;

  localparam int          NS   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0020_0000;
  localparam logic [31:0] SIZE = 32'h0004_0000;

  logic         ahb_clk = 1'b0;
  logic         ahb_reset;
  logic         HSEL, HWRITE, HREADY;
  logic [31:0]  HADDR, HWDATA;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [3:0]   HPROT;
  logic         HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [31:0]  HRDATA, PADDR, PWDATA;
  logic [3:0]   PSEL, PREADY, PSLVERR;
  logic [127:0] PRDATA;
  logic [2:0]   dbg_state;
`ifdef AHB2APB_APB4_EN
  logic [3:0]   PSTRB;
  logic [2:0]   PPROT;
`endif

  ahb2apb_bridge_mp #(.TIMEOUT(TO)) dut (
    .ahb_clk(ahb_clk), .ahb_reset(ahb_reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR),
`ifdef AHB2APB_APB4_EN
    .PSTRB(PSTRB), .PPROT(PPROT),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ahb_clk = ~ahb_clk;

  typedef struct {
    logic        hreadyout;
    logic        hresp;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last_rec;
  exp_t        reset_rec;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_paddr, m_pwdata, m_hrdata;
  logic        m_pwrite;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;

  // APB slave responders
  int          cfg_wait[NS];
  bit          cfg_err[NS];
  bit          cfg_hang[NS];
  logic [31:0] cfg_rdata[NS];
  int          acc_cnt = 0;

  always @(posedge ahb_clk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  always @* begin
    for (int i = 0; i < NS; i++) begin
      PREADY[i]            = PSEL[i] && PENABLE && !cfg_hang[i] && (acc_cnt >= cfg_wait[i]);
      PSLVERR[i]           = PREADY[i] && cfg_err[i];
      PRDATA[i*32 +: 32]   = cfg_rdata[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [1:0] a);
    int nb;
    int lane;
    nb = 1 << size;
    if (nb >= 4) return 4'hf;
    lane = int'(a) - (int'(a) % nb);
    return 4'((1 << nb) - 1) << lane;
  endfunction

  // scoreboard: one expected record per cycle while a transfer is in flight, idle otherwise
  always @(negedge ahb_clk) begin
    if (chk_en) begin
      exp_t e;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_rec = e;
      end else begin
        e = last_rec;
        e.hreadyout = 1'b1;
        e.hresp     = 1'b0;
        e.psel      = 4'h0;
        e.penable   = 1'b0;
      end
      check("hreadyout", 64'(HREADYOUT), 64'(e.hreadyout));
      check("hresp", 64'(HRESP), 64'(e.hresp));
      check("psel", 64'(PSEL), 64'(e.psel));
      check("penable", 64'(PENABLE), 64'(e.penable));
      check("paddr", 64'(PADDR), 64'(e.paddr));
      check("pwrite", 64'(PWRITE), 64'(e.pwrite));
      check("pwdata", 64'(PWDATA), 64'(e.pwdata));
      check("hrdata", 64'(HRDATA), 64'(e.hrdata));
`ifdef AHB2APB_APB4_EN
      if (e.psel != 4'h0) begin
        check("pstrb", 64'(PSTRB), 64'(e.pstrb));
        check("pprot", 64'(PPROT), 64'(e.pprot));
      end
`endif
    end
  end

  // driver: one AHB transfer, issued now (at a negedge), returns at the negedge HREADYOUT is high
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [2:0] size, input logic [3:0] prot, input int exp_low);
    logic [31:0] off;
    int          idx, nacc, low;
    bit          hit, fail;
    exp_t        r;
    HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HPROT = prot; HREADY = 1'b1;
    @(posedge ahb_clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    off  = addr - BASE;
    hit  = off < (32'(NS) * SIZE);
    idx  = int'(off / SIZE);
    fail = 1'b1;
    if (hit) begin
      m_paddr  = addr;
      m_pwrite = wr;
      if (wr) m_pwdata = wdata;
      m_pstrb = wr ? model_strb(size, addr[1:0]) : 4'h0;
      m_pprot = {~prot[0], 1'b1, prot[1]};
    end
    r = '{hreadyout: 1'b0, hresp: 1'b0, psel: 4'h0, penable: 1'b0, paddr: m_paddr, pwrite: m_pwrite,
          pwdata: m_pwdata, hrdata: m_hrdata, pstrb: m_pstrb, pprot: m_pprot};
    if (hit) begin
      r.psel = 4'(1 << idx);
      exp_q.push_back(r);
      nacc = cfg_hang[idx] ? TO : cfg_wait[idx] + 1;
      r.penable = 1'b1;
      for (int k = 0; k < nacc; k++) exp_q.push_back(r);
      fail = cfg_hang[idx] || cfg_err[idx];
    end
    r.psel = 4'h0;
    r.penable = 1'b0;
    if (fail) begin
      r.hresp = 1'b1;
      exp_q.push_back(r);
      r.hreadyout = 1'b1;
      exp_q.push_back(r);
    end else begin
      if (!wr) m_hrdata = cfg_rdata[idx];
      r.hrdata = m_hrdata;
      r.hreadyout = 1'b1;
      exp_q.push_back(r);
    end
    low = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge ahb_clk);
      if (HREADYOUT) break;
      low++;
      @(posedge ahb_clk); #1;
    end
    check("wait_states", 64'(low), 64'(exp_low));
  endtask

  task automatic idle_cycle(input logic sel, input logic [1:0] trans, input logic rdy);
    HSEL = sel; HTRANS = trans; HREADY = rdy; HWRITE = 1'b1; HADDR = BASE;
    @(posedge ahb_clk);
    @(negedge ahb_clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0; m_pstrb = '0; m_pprot = '0;
    last_rec = reset_rec;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_rec = '{hreadyout: 1'b1, hresp: 1'b0, psel: 4'h0, penable: 1'b0, paddr: 32'h0, pwrite: 1'b0,
                  pwdata: 32'h0, hrdata: 32'h0, pstrb: 4'h0, pprot: 3'h0};
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HPROT = 4'h0;
    HWDATA = '0; HREADY = 1'b1;
    for (int i = 0; i < NS; i++) begin
      cfg_wait[i] = 0; cfg_err[i] = 1'b0; cfg_hang[i] = 1'b0; cfg_rdata[i] = 32'h1111_1111 * (i + 1);
    end
    ahb_reset = 1'b1;
    repeat (3) @(posedge ahb_clk);
    @(negedge ahb_clk);
    check("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    check("rst_hresp", 64'(HRESP), 64'd0);
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_hrdata", 64'(HRDATA), 64'd0);
    ahb_reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    idle_cycle(1'b0, 2'b00, 1'b1);

    // zero-wait write to slave 0
    xfer(32'h0020_0010, 1'b1, 32'hDEAD_BEEF, 3'd2, 4'h0, 2);
    check("t1_pwdata_hold", 64'(PWDATA), 64'h0000_0000_DEAD_BEEF);
    check("t1_hresp", 64'(HRESP), 64'd0);

    // read slave 1 with two APB wait states
    cfg_wait[1] = 2; cfg_rdata[1] = 32'h1234_5678;
    xfer(32'h0024_0004, 1'b0, 32'h0, 3'd2, 4'h0, 4);
    check("t2_hrdata", 64'(HRDATA), 64'h0000_0000_1234_5678);

    // slave error on slave 2, then a miss issued back-to-back in the ERR2 cycle
    cfg_err[2] = 1'b1;
    xfer(32'h0028_0008, 1'b1, 32'hCAFE_F00D, 3'd2, 4'h0, 3);
    check("t3_err2_hresp", 64'(HRESP), 64'd1);
    xfer(32'h0030_0000, 1'b0, 32'h0, 3'd2, 4'h0, 1);
    check("t4_hrdata_kept", 64'(HRDATA), 64'h0000_0000_1234_5678);

    // ERR2-phase cancel, then ignored patterns: IDLE trans, HREADY low, HSEL low
    idle_cycle(1'b1, 2'b00, 1'b1);
    idle_cycle(1'b1, 2'b10, 1'b0);
    idle_cycle(1'b0, 2'b10, 1'b1);
    idle_cycle(1'b1, 2'b01, 1'b1);

    // back-to-back transfers and window boundaries
    cfg_rdata[0] = 32'hA5A5_0F0F; cfg_wait[3] = 1;
    xfer(32'h0020_0000, 1'b0, 32'h0, 3'd2, 4'h0, 2);
    xfer(32'h002C_000C, 1'b1, 32'h0BAD_F00D, 3'd2, 4'h0, 3);
    xfer(32'h002F_FFFC, 1'b0, 32'h0, 3'd2, 4'h0, 3);
    check("t6_pwdata_hold", 64'(PWDATA), 64'h0000_0000_0BAD_F00D);
    xfer(32'h001F_FFFC, 1'b1, 32'h5555_AAAA, 3'd2, 4'h0, 1);
    xfer(32'h0021_0000, 1'b1, 32'h7777_8888, 3'd2, 4'h0, 2);

    // PREADY timeout on slave 3
    cfg_wait[3] = 0; cfg_hang[3] = 1'b1;
    xfer(32'h002C_0000, 1'b1, 32'h1357_9BDF, 3'd2, 4'h0, 1 + TO + 1);
    idle_cycle(1'b0, 2'b00, 1'b1);

    // reset in the middle of an ACCESS
    chk_en = 1'b0;
    HSEL = 1'b1; HADDR = 32'h002C_0010; HTRANS = 2'b10; HWRITE = 1'b0;
    @(posedge ahb_clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(posedge ahb_clk);
    @(negedge ahb_clk);
    check("mid_psel", 64'(PSEL), 64'h8);
    check("mid_penable", 64'(PENABLE), 64'd1);
    ahb_reset = 1'b1;
    @(negedge ahb_clk);
    check("rst2_psel", 64'(PSEL), 64'd0);
    check("rst2_penable", 64'(PENABLE), 64'd0);
    check("rst2_hreadyout", 64'(HREADYOUT), 64'd1);
    check("rst2_hrdata", 64'(HRDATA), 64'd0);
    check("rst2_paddr", 64'(PADDR), 64'd0);
    ahb_reset = 1'b0;
    cfg_hang[3] = 1'b0;
    model_reset();
    chk_en = 1'b1;
    idle_cycle(1'b0, 2'b00, 1'b1);
    xfer(32'h0020_0020, 1'b1, 32'h0BAD_F00D, 3'd2, 4'h0, 2);
    xfer(32'h0020_0020, 1'b0, 32'h0, 3'd2, 4'h0, 2);
    check("t10_hrdata", 64'(HRDATA), 64'h0000_0000_A5A5_0F0F);

`ifdef AHB2APB_APB4_EN
    xfer(32'h0020_0002, 1'b1, 32'h00AB_0000, 3'd0, 4'b0011, 2);
    check("apb4_pstrb", 64'(PSTRB), 64'h4);
    check("apb4_pprot", 64'(PPROT), 64'h3);
    xfer(32'h0020_0002, 1'b1, 32'hABCD_0000, 3'd1, 4'b0000, 2);
    check("apb4_pstrb_half", 64'(PSTRB), 64'hC);
    xfer(32'h0020_0004, 1'b0, 32'h0, 3'd2, 4'b0001, 2);
    check("apb4_pstrb_read", 64'(PSTRB), 64'h0);
`endif

    repeat (3) idle_cycle(1'b0, 2'b00, 1'b1);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
